stream_rr_arbiter: RTL
======================

Name: stream_rr_arbiter

Overview:
- Merges num_req_p independent valid/ready producer streams onto one downstream valid/ready stream, using round-robin arbitration with packet locking.
- The typical downstream is the data_i/valid_i/ready_o side of fifo_1r1w.
- The block lets several requesters share one FIFO without interleaving beats inside a packet.
- The output is a single registered pipeline stage, so the block has one cycle of latency.

Parameters:
- width_p, 8, data width of each beat.
- num_req_p, 4, number of requesters; must be at least 1.
- id_width_p, $clog2(num_req_p) with a minimum of 1, width of the source id field.

Ports:
- clk_i  in  1  single clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- data_i  in  num_req_p*width_p  packed request data; channel k occupies bits [k*width_p +: width_p].
- valid_i  in  num_req_p  per-channel beat valid.
- last_i  in  num_req_p  per-channel end-of-packet flag, qualified by valid_i.
- ready_o  out  num_req_p  per-channel accept.
- valid_o  out  1  downstream beat valid.
- data_o  out  width_p  downstream data.
- id_o  out  id_width_p  index of the source channel of the current output beat.
- last_o  out  1  end-of-packet flag of the output beat.
- ready_i  in  1  downstream accept; connect to fifo_1r1w ready_o.

Behaviour:
- Reset, while reset_i=1 at a posedge:
  - valid_o=0, data_o=0, id_o=0, last_o=0.
  - Round-robin pointer ptr=0; state=IDLE; lock_id=0.
  - ready_o is forced to all zeros combinationally whenever reset_i=1.
- Handshake:
  - A beat is accepted on channel k when valid_i[k] & ready_o[k] at a posedge.
  - At most one ready_o bit is high in any cycle.
  - ready_o may depend on valid_i. Producers must not make valid_i depend on ready_o.
  - Downstream transfer happens on valid_o & ready_i.
- Output stage:
  - can_take = ~valid_o | ready_i.
  - On an accept: valid_o<=1; data_o, id_o and last_o load the granted channel's values.
  - Otherwise, if ready_i: valid_o<=0.
  - data_o, id_o and last_o hold while valid_o=1 and ready_i=0.
  - Full throughput: one beat per cycle when ready_i stays high.
- State IDLE (no packet in progress):
  - g = first k with valid_i[k]=1, searching ptr, ptr+1, ..., num_req_p-1, 0, ..., ptr-1.
  - ready_o[g] = can_take; all other ready_o bits are 0; ready_o is all zeros if no channel is valid.
  - On an accept with last_i[g]=1: stay IDLE; ptr <= (g+1) mod num_req_p.
  - On an accept with last_i[g]=0: go to LOCKED; lock_id <= g.
- State LOCKED:
  - ready_o[lock_id] = can_take; all other bits are 0, whatever valid_i the other channels present.
  - On an accept with last_i[lock_id]=1: go to IDLE; ptr <= (lock_id+1) mod num_req_p.
- Fairness: a waiting channel is granted after at most num_req_p-1 other packets.
- Wrap-around: ptr goes from num_req_p-1 to 0. With num_req_p=1, ptr stays 0 and id_o=0.
- Boundary conditions:
  - No valid channel: nothing changes; the output drains if ready_i=1.
  - A channel dropping valid_i mid-packet while LOCKED: the lock holds and other channels stay blocked.
  - Reset mid-packet: the lock is discarded and the buffered output beat is dropped; there is no partial-packet recovery.
  - Downstream backpressure at any point: no beat is lost or duplicated.

Decomposition:
- Shared package holds:
  - state enum arb_state_e {IDLE, LOCKED};
  - a function for the id width: clog2 with a minimum of 1.
- Sub-module rr_pick holds the purely combinational search:
  - inputs: a num_req_p request vector and ptr;
  - outputs: a found flag and a grant index.
- The top module holds the FSM, ptr, lock_id and the output register.

Test Plan (num_req_p=4, width_p=8):
1. Reset:
   - Stimulus: hold reset_i=1 for 3 cycles with valid_i=4'b1111.
   - Required: ready_o=0000 and valid_o=0 throughout.
   - On the first cycle after release: ready_o=0001.
2. Round robin:
   - Stimulus: all channels valid with single-beat packets (last_i=1111), data 0xA0, 0xB0, 0xC0, 0xD0; ready_i=1.
   - Required: grants go 0,1,2,3,0.
   - id_o sequence is 0,1,2,3 with data A0,B0,C0,D0, each appearing one cycle after its accept.
3. Packet lock:
   - Stimulus: ch2 sends 0x21, 0x22, 0x23 with last on 0x23; ch0 and ch1 are continuously valid; ptr=2.
   - Required: ready_o=0100 for three accepts.
   - Then ptr=3; ch3 is idle, so ch0 is granted next.
   - The output shows 21,22,23 contiguously with last_o only on 0x23.
4. Backpressure:
   - Stimulus: valid_o=1, data_o=0x55, then ready_i=0 for 5 cycles.
   - Required: data_o=0x55 is stable and ready_o=0000.
   - When ready_i returns to 1, the next beat follows with no loss or duplication.
5. Wrap:
   - Stimulus: only ch3 and ch0 valid, single-beat packets.
   - Required: grant order is 3,0,3,0 starting from ptr=3.
6. End to end:
   - Stimulus: connect to fifo_1r1w (depth 17); random valid_i/last_i; random ready on the FIFO read side for 1000 cycles.
   - Required: the scoreboard sees per-channel order preserved, no interleaving within a packet, and no lost beats.

Source files
------------

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_rr_arbiter_pkg;

   // Arbiter is either free to pick a new packet or locked to one channel.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Width of a channel index; never narrower than one bit.
   function automatic int id_width_f(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping around to channel 0.
module stream_rr_arbiter_rr_pick
   import stream_rr_arbiter_pkg::*;
#(
   parameter int num_req_p  = 4,
   parameter int id_width_p = id_width_f(num_req_p)
) (
   input  logic [num_req_p-1:0]  req,
   input  logic [id_width_p-1:0] ptr,
   output logic                  found,
   output logic [id_width_p-1:0] grant
);

   // Two passes: channels ptr..N-1 first, then the wrapped range 0..ptr-1.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int k = 0; k < num_req_p; k++) begin
         if (!found && req[k] && (k >= int'(ptr))) begin
            found = 1'b1;
            grant = id_width_p'(k);
         end
      end
      for (int k = 0; k < num_req_p; k++) begin
         if (!found && req[k]) begin
            found = 1'b1;
            grant = id_width_p'(k);
         end
      end
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Merges several valid/ready producer streams onto one registered output
// stream. Packets are never interleaved: once a multi-beat packet starts,
// the winning channel keeps the grant until its last beat is accepted.
module stream_rr_arbiter
   import stream_rr_arbiter_pkg::*;
#(
   parameter int width_p    = 8,
   parameter int num_req_p  = 4,
   parameter int id_width_p = id_width_f(num_req_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [num_req_p*width_p-1:0] data_i,
   input  logic [num_req_p-1:0]         valid_i,
   input  logic [num_req_p-1:0]         last_i,
   output logic [num_req_p-1:0]         ready_o,
   output logic                         valid_o,
   output logic [width_p-1:0]           data_o,
   output logic [id_width_p-1:0]        id_o,
   output logic                         last_o,
   input  logic                         ready_i
);

   arb_state_e              state, state_nxt;
   logic [id_width_p-1:0]   ptr, ptr_nxt;
   logic [id_width_p-1:0]   lock_id, lock_nxt;
   logic [id_width_p-1:0]   grant, sel;
   logic                    found, can_take, sel_valid, accept, sel_last;
   logic [width_p-1:0]      sel_data;

   // Successor of a channel index, wrapping from the last channel to 0.
   function automatic logic [id_width_p-1:0] next_idx(input logic [id_width_p-1:0] i);
      if (int'(i) >= num_req_p - 1) return '0;
      return i + 1'b1;
   endfunction

   stream_rr_arbiter_rr_pick #(
      .num_req_p  (num_req_p),
      .id_width_p (id_width_p)
   ) u_pick (
      .req   (valid_i),
      .ptr   (ptr),
      .found (found),
      .grant (grant)
   );

   // Grant selection: the locked channel wins outright, otherwise the
   // round-robin pick; the output register must have room to take a beat.
   always_comb begin
      can_take  = ~valid_o | ready_i;
      sel       = (state == LOCKED) ? lock_id : grant;
      sel_valid = (state == LOCKED) | found;
      ready_o   = '0;
      if (!reset_i && sel_valid && can_take) ready_o[sel] = 1'b1;
      accept    = |(valid_i & ready_o);
      sel_data  = data_i[sel*width_p +: width_p];
      sel_last  = last_i[sel];
   end

   // Next-state logic for the packet lock and the round-robin pointer.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      lock_nxt  = lock_id;
      case (state)
         IDLE: begin
            if (accept) begin
               if (sel_last) begin
                  ptr_nxt = next_idx(sel);
               end else begin
                  state_nxt = LOCKED;
                  lock_nxt  = sel;
               end
            end
         end
         LOCKED: begin
            if (accept && sel_last) begin
               state_nxt = IDLE;
               ptr_nxt   = next_idx(lock_id);
            end
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state   <= IDLE;
         ptr     <= '0;
         lock_id <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         lock_id <= lock_nxt;
      end
   end

   // Output stage: loads on accept, drains on downstream ready, holds otherwise.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         id_o    <= '0;
         last_o  <= 1'b0;
      end else if (accept) begin
         valid_o <= 1'b1;
         data_o  <= sel_data;
         id_o    <= sel;
         last_o  <= sel_last;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule
